// File: rtl/systolic_feeder_4x4.sv
// Operand staging and diagonal-skew feeder for a 4x4 systolic multiply array.
// Buffers one 4x4 A matrix and one 4x4 B matrix loaded row by row. On start
// it clears the array accumulators, streams both matrices in skewed order
// with zero padding, idles the lanes while the array drains, then pulses done.
module systolic_feeder_4x4 #(
    parameter int DW           = 32,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sel,
    input  logic [1:0]      in_row,
    input  logic [4*DW-1:0] in_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            acc_clr,
    output logic            feed_valid,
    output logic [DW-1:0]   a_lane0,
    output logic [DW-1:0]   a_lane1,
    output logic [DW-1:0]   a_lane2,
    output logic [DW-1:0]   a_lane3,
    output logic [DW-1:0]   b_lane0,
    output logic [DW-1:0]   b_lane1,
    output logic [DW-1:0]   b_lane2,
    output logic [DW-1:0]   b_lane3
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    // Last skew beat index: lane 3 receives its final element at t = 3 + 3.
    localparam logic [2:0] T_LAST    = 3'd6;
    localparam logic [7:0] DRAIN_END = 8'(DRAIN_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    t_cnt;
    logic [2:0]    t_nxt;
    logic [7:0]    drain_cnt;
    logic [7:0]    drain_nxt;

    logic [DW-1:0] a_buf [4][4];
    logic [DW-1:0] b_buf [4][4];

    logic [DW-1:0] a_lane_q [4];
    logic [DW-1:0] b_lane_q [4];
    logic [DW-1:0] a_lane_d [4];
    logic [DW-1:0] b_lane_d [4];

    logic          load_fire;

    // Loads are only accepted while idle, so the buffers are stable during a sequence.
    assign load_fire = in_valid && in_ready;

    // Operand buffers: one row written per accepted beat, lane k -> column k.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: these buffers are small flop arrays, not RAM, so clearing
            // them on reset is cheap and gives a defined replay after an abort.
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    a_buf[r][c] <= '0;
                    b_buf[r][c] <= '0;
                end
            end
        end else if (load_fire) begin
            for (int c = 0; c < 4; c++) begin
                if (in_sel) begin
                    b_buf[in_row][c] <= in_data[c*DW +: DW];
                end else begin
                    a_buf[in_row][c] <= in_data[c*DW +: DW];
                end
            end
        end
    end

    // Sequencer next-state: CLEAR for one cycle, seven skewed beats, drain, done.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        t_nxt     = t_cnt;
        drain_nxt = drain_cnt;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_nxt = S_FEED;
                t_nxt     = 3'd0;
            end
            S_FEED: begin
                if (t_cnt == T_LAST) begin
                    state_nxt = S_DRAIN;
                    drain_nxt = 8'd0;
                end else begin
                    t_nxt = t_cnt + 3'd1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_END) begin
                    state_nxt = S_DONE;
                end else begin
                    drain_nxt = drain_cnt + 8'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Skewed lane values for the upcoming cycle: a_lane i carries A[i][k] and
    // b_lane j carries B[k][j] exactly when the beat index equals lane + k.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_lane_d[i] = '0;
            b_lane_d[i] = '0;
        end
        if (state_nxt == S_FEED) begin
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 4; k++) begin
                    if (t_nxt == 3'(i + k)) begin
                        a_lane_d[i] = a_buf[i][k];
                        b_lane_d[i] = b_buf[k][i];
                    end
                end
            end
        end
    end

    // State, counters and lane registers; lanes for a cycle load on the edge entering it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            t_cnt     <= 3'd0;
            drain_cnt <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                a_lane_q[i] <= '0;
                b_lane_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed by the combinational blocks.
            state     <= state_nxt;
            t_cnt     <= t_nxt;
            drain_cnt <= drain_nxt;
            for (int i = 0; i < 4; i++) begin
                a_lane_q[i] <= a_lane_d[i];
                b_lane_q[i] <= b_lane_d[i];
            end
        end
    end

    // Control outputs are pure decodes of the registered state.
    assign in_ready   = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign acc_clr    = (state == S_CLEAR);
    assign feed_valid = (state == S_FEED);

    assign a_lane0 = a_lane_q[0];
    assign a_lane1 = a_lane_q[1];
    assign a_lane2 = a_lane_q[2];
    assign a_lane3 = a_lane_q[3];
    assign b_lane0 = b_lane_q[0];
    assign b_lane1 = b_lane_q[1];
    assign b_lane2 = b_lane_q[2];
    assign b_lane3 = b_lane_q[3];

endmodule

// File: doc/systolic_feeder_4x4.md
Name: systolic_feeder_4x4

Overview:
Operand staging and skew stage directly upstream of the 4x4 systolic multiply array. It buffers one 4x4 A matrix and one 4x4 B matrix, written row by row over a valid/ready load port. On start it clears the array accumulators, then streams the operands in diagonal-skewed order with zero padding onto the array's four A-lane and four B-lane inputs. It then idles the lanes long enough for the array to drain and signals done.

Parameters:
DW, 32, operand width in bits for every lane and every storage element.
DRAIN_CYCLES, 8, number of zero-padding cycles after the last skewed beat before done is raised; legal range 1..255.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  load beat valid.
in_ready  output  1  load beat accepted when in_valid and in_ready are both high on a rising edge.
in_sel  input  1  0 = write into A buffer, 1 = write into B buffer.
in_row  input  2  row index 0..3 to write.
in_data  input  4*DW  row data; lane k is bits [k*DW +: DW] and holds column k.
start  input  1  single-cycle request to begin a feed sequence.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse at the end of a sequence.
acc_clr  output  1  accumulator clear for the array; drives the array's reset input.
feed_valid  output  1  high while the lanes carry skewed beats (FEED state).
a_lane0..a_lane3  output  DW each  drive array inputs a, b, c, d.
b_lane0..b_lane3  output  DW each  drive array inputs e, f, g, h.

Behaviour:
- Reset: one clock, synchronous active-high, as already decided.
  - Reset clears both buffers to 0 and forces state IDLE.
  - All outputs are 0 after reset except in_ready, which is 1.
  - Reset asserted mid-sequence aborts it on that edge. No done pulse is produced and the lanes are 0 on the next cycle.
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - in_ready=1; an accepted beat writes in_data to buffer[in_sel][in_row].
  - start=1 moves to CLEAR. start in any other state is ignored and is not queued.
- Load and start on the same edge in IDLE: the write takes effect and start is also accepted. The written row is used by the sequence.
- CLEAR: exactly 1 cycle. acc_clr=1 and lanes 0. Next state FEED with feed counter t=0.
- FEED: 7 cycles, t = 0..6.
  - feed_valid=1.
  - a_lane i = A[i][t-i] if 0 <= t-i <= 3, else 0.
  - b_lane j = B[t-j][j] if 0 <= t-j <= 3, else 0.
  - At t=6, next state is DRAIN.
- DRAIN: DRAIN_CYCLES cycles. Lanes 0, feed_valid 0. Then DONE.
- DONE: 1 cycle with done=1 and busy=1, then IDLE.
- Lane and control outputs are registered: the value for cycle t is loaded on the edge entering that cycle. No combinational path runs from any input to any output except none; in_ready is a state decode.
- in_ready=0 in every non-IDLE state. Beats offered then are not accepted and the buffers are unchanged.
- Buffers are not cleared by a sequence. A second start with no new loads replays the same matrices.
- busy=1 from CLEAR through DONE inclusive.
- Timing: with start sampled on edge E0, the cycle numbering is:
  - cycle 1: CLEAR
  - cycles 2..8: FEED
  - cycles 9..8+DRAIN_CYCLES: DRAIN
  - cycle 9+DRAIN_CYCLES: DONE, i.e. cycle 17 at default.
- No arithmetic and no width growth: data passes through bit-exact.

Test Plan:
- Reset then idle: assert rst for 2 cycles -> all lanes 0, busy=0, done=0, acc_clr=0, in_ready=1.
- Load and feed:
  - Stimulus: load A[i][j]=4i+j+1 and B[i][j]=100+4i+j (8 beats), then start.
  - cycle 1: acc_clr=1.
  - FEED t=0: a lanes {1,0,0,0}, b lanes {100,0,0,0}.
  - FEED t=3: a lanes {4,7,10,13}, b lanes {112,109,106,103}.
  - FEED t=6: a lanes {0,0,0,16}, b lanes {0,0,0,115}.
  - done pulses exactly at cycle 17 after start.
- Load during busy: in_valid=1 with in_sel=0, in_row=0, data all 0xFFFFFFFF during FEED -> in_ready=0 and the buffer is unchanged. A replay start yields a_lane0=1 at t=0.
- Start ignored: a second start pulse during DRAIN -> no restart, a single done at cycle 17, then IDLE for at least 1 cycle.
- Simultaneous load and start: in IDLE, write row A0 = {9,9,9,9} on the same edge as start -> a_lane0 shows 9 at FEED t=0.
- Reset mid-op: rst asserted at FEED t=3 -> next cycle all lanes 0, busy=0, in_ready=1, no done pulse, and buffers read back 0 on the subsequent sequence.
